// File: rtl/sprite_pkg.sv
// Shared widths, types and the pixel-select helper for the sprite line-buffer writer.
package sprite_pkg;

  localparam int PIX_W_DFLT = 4;
  localparam int X_W_DFLT   = 8;
  localparam int NPIX_DFLT  = 8;
  localparam int GFX_W_DFLT = NPIX_DFLT * PIX_W_DFLT;

  typedef logic [PIX_W_DFLT-1:0] pix_t;
  typedef logic [X_W_DFLT-1:0]   xaddr_t;
  typedef logic [GFX_W_DFLT-1:0] gfx_t;

  // idx counts pixels in emission order; unflipped sprites start from the top nibble.
  function automatic pix_t nibble_sel(input gfx_t word, input int unsigned idx, input logic flip);
    int unsigned sel;
    sel = flip ? idx : (NPIX_DFLT - 1 - idx);
    return pix_t'(word >> (sel * PIX_W_DFLT));
  endfunction

endpackage

// File: rtl/linebuf_bank.sv
// One line-buffer bank: simple dual-port RAM, synchronous write, registered read-first.
module linebuf_bank #(
  parameter int AW = 8,
  parameter int DW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-edge write to raddr lands after this read, giving read-before-clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_linebuf_writer.sv
// k503 sprite consumer: strobe edge detect, pixel shifter and ping-pong line buffer
// with clear-behind-read on the display bank.
module sprite_linebuf_writer #(
  parameter int PIX_W = 4,
  parameter int X_W   = 8,
  parameter int NPIX  = 8
) (
  input  logic                  CK49,
  input  logic                  RESET_N,
  input  logic                  CEN,
  input  logic                  OCS,
  input  logic                  OFLP,
  input  logic                  OCOL,
  input  logic                  ODAT,
  input  logic [X_W-1:0]        XPOS,
  input  logic [NPIX*PIX_W-1:0] GFX,
  input  logic                  VBANK,
  input  logic [X_W-1:0]        HCNT,
  output logic [PIX_W-1:0]      PIX_OUT,
  output logic                  BUSY
);

  import sprite_pkg::*;

  localparam int GFX_W = NPIX * PIX_W;
  localparam int CNT_W = $clog2(NPIX + 1);
  typedef logic [CNT_W-1:0] count_t;

  logic             ocol_prev_q, odat_prev_q, vbank_prev_q;
  logic [X_W-1:0]   x_latch_q, x_latch_d;
  logic [GFX_W-1:0] word_q, word_d;
  logic             flip_q, flip_d;
  count_t           count_q, count_d;
  logic [X_W-1:0]   waddr_q, waddr_d;
  logic             busy_q, busy_d;
  logic             rd_bank_q;

  logic             ocol_fall, odat_fall, load, bank_toggle, emit;
  logic [PIX_W-1:0] emit_pix;
  logic             pix_we;
  logic [PIX_W-1:0] bank_rdata [2];

  always_comb begin
    ocol_fall   = CEN & ~OCOL & ocol_prev_q;
    odat_fall   = CEN & ~ODAT & odat_prev_q;
    load        = odat_fall & ~OCS;
    bank_toggle = CEN & (VBANK != vbank_prev_q);
    emit        = CEN & (count_q != '0) & ~load & ~bank_toggle;
    emit_pix    = nibble_sel(word_q, int'(NPIX) - int'(count_q), flip_q);
    pix_we      = emit & (emit_pix != '0);
  end

  // A load outranks a bank toggle so a word strobed on the toggle edge lands in the new bank.
  always_comb begin
    x_latch_d = x_latch_q;
    word_d    = word_q;
    flip_d    = flip_q;
    count_d   = count_q;
    waddr_d   = waddr_q;
    if (ocol_fall) begin
      x_latch_d = XPOS;
    end
    if (load) begin
      word_d  = GFX;
      flip_d  = OFLP;
      count_d = count_t'(NPIX);
      waddr_d = ocol_fall ? XPOS : x_latch_q;
    end else if (bank_toggle) begin
      count_d = '0;
    end else if (emit) begin
      waddr_d = waddr_q + X_W'(1);
      count_d = count_q - CNT_W'(1);
    end
    busy_d = (count_d != '0);
  end

  always_ff @(posedge CK49 or negedge RESET_N) begin
    if (!RESET_N) begin
      ocol_prev_q  <= 1'b1;
      odat_prev_q  <= 1'b1;
      vbank_prev_q <= 1'b0;
      x_latch_q    <= '0;
      word_q       <= '0;
      flip_q       <= 1'b0;
      count_q      <= '0;
      waddr_q      <= '0;
      busy_q       <= 1'b0;
      rd_bank_q    <= 1'b1;
    end else if (CEN) begin
      ocol_prev_q  <= OCOL;
      odat_prev_q  <= ODAT;
      vbank_prev_q <= VBANK;
      x_latch_q    <= x_latch_d;
      word_q       <= word_d;
      flip_q       <= flip_d;
      count_q      <= count_d;
      waddr_q      <= waddr_d;
      busy_q       <= busy_d;
      rd_bank_q    <= ~VBANK;
    end
  end

  // The write bank sees only sprite pixels; the display bank sees only clears at HCNT.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic             is_wr_bank;
    logic             we;
    logic [X_W-1:0]   waddr;
    logic [PIX_W-1:0] wdata;
    logic             re;

    assign is_wr_bank = (VBANK == 1'(gi));
    assign we         = is_wr_bank ? pix_we : CEN;
    assign waddr      = is_wr_bank ? waddr_q : HCNT;
    assign wdata      = is_wr_bank ? emit_pix : '0;
    assign re         = ~is_wr_bank & CEN;

    linebuf_bank #(
      .AW(X_W),
      .DW(PIX_W)
    ) u_bank (
      .clk_i  (CK49),
      .rst_ni (RESET_N),
      .we_i   (we),
      .waddr_i(waddr),
      .wdata_i(wdata),
      .re_i   (re),
      .raddr_i(HCNT),
      .rdata_o(bank_rdata[gi])
    );
  end

  assign PIX_OUT = bank_rdata[rd_bank_q];
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_sprite_linebuf_writer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_sprite_linebuf_writer;

  localparam int PIX_W = 4;
  localparam int X_W   = 8;
  localparam int NPIX  = 8;

  logic                  CK49 = 1'b0;
  logic                  RESET_N = 1'b1;
  logic                  CEN = 1'b1;
  logic                  OCS = 1'b1;
  logic                  OFLP = 1'b0;
  logic                  OCOL = 1'b1;
  logic                  ODAT = 1'b1;
  logic [X_W-1:0]        XPOS = '0;
  logic [NPIX*PIX_W-1:0] GFX = '0;
  logic                  VBANK = 1'b0;
  logic [X_W-1:0]        HCNT = '0;
  logic [PIX_W-1:0]      PIX_OUT;
  logic                  BUSY;

  int n_cmp = 0;
  int n_fail = 0;

  sprite_linebuf_writer #(.PIX_W(PIX_W), .X_W(X_W), .NPIX(NPIX)) dut (
    .CK49(CK49), .RESET_N(RESET_N), .CEN(CEN), .OCS(OCS), .OFLP(OFLP),
    .OCOL(OCOL), .ODAT(ODAT), .XPOS(XPOS), .GFX(GFX), .VBANK(VBANK),
    .HCNT(HCNT), .PIX_OUT(PIX_OUT), .BUSY(BUSY)
  );

  always #5 CK49 = ~CK49;

  // Reference model: a load expands into a list of pending (addr, pixel) writes.
  typedef struct { int addr; int pix; } wr_t;
  wr_t m_pend[$];
  int  m_mem [2][256];
  int  m_xl;
  bit  m_ocol_prev, m_odat_prev, m_vb_prev;
  int  exp_pix;
  bit  exp_busy;

  function automatic void model_reset();
    exp_pix = 0;
    exp_busy = 0;
    m_pend.delete();
    m_xl = 0;
    m_ocol_prev = 1;
    m_odat_prev = 1;
    m_vb_prev = 0;
  endfunction

  function automatic void model_edge();
    bit ocol_f, odat_f, tog;
    int wb, rb, base;
    if (CEN !== 1'b1) return;
    ocol_f = (OCOL == 1'b0) && m_ocol_prev;
    odat_f = (ODAT == 1'b0) && m_odat_prev;
    tog    = (VBANK != m_vb_prev);
    wb = int'(VBANK);
    rb = 1 - wb;
    exp_pix = m_mem[rb][HCNT];
    m_mem[rb][HCNT] = 0;
    if (odat_f && OCS == 1'b0) begin
      base = ocol_f ? int'(XPOS) : m_xl;
      m_pend.delete();
      for (int j = 0; j < NPIX; j++) begin
        wr_t w;
        int src;
        src = OFLP ? j : NPIX - 1 - j;
        w.addr = (base + j) % 256;
        w.pix = int'(GFX[src*PIX_W +: PIX_W]);
        m_pend.push_back(w);
      end
    end else if (tog) begin
      m_pend.delete();
    end else if (m_pend.size() > 0) begin
      wr_t w;
      w = m_pend.pop_front();
      if (w.pix != 0) m_mem[wb][w.addr] = w.pix;
    end
    if (ocol_f) m_xl = int'(XPOS);
    m_ocol_prev = OCOL;
    m_odat_prev = ODAT;
    m_vb_prev = VBANK;
    exp_busy = (m_pend.size() != 0);
  endfunction

  task automatic tick();
    model_edge();
    @(posedge CK49);
    @(negedge CK49);
  endtask

  task automatic idle(input int n);
    OCOL = 1'b1;
    ODAT = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic col(input logic [X_W-1:0] x);
    OCOL = 1'b0;
    XPOS = x;
    tick();
    OCOL = 1'b1;
  endtask

  task automatic dat(input logic [31:0] g, input logic f, input logic cs);
    ODAT = 1'b0;
    GFX = g;
    OFLP = f;
    OCS = cs;
    tick();
    ODAT = 1'b1;
    OCS = 1'b1;
  endtask

  task automatic set_bank(input logic b);
    VBANK = b;
    tick();
  endtask

  task automatic test_reset();
    #1 RESET_N = 1'b0;
    #11;
    n_cmp++;
    if (PIX_OUT !== 4'h0) begin n_fail++; $display("FAIL reset_pix got=%0h want=0", PIX_OUT); end
    n_cmp++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", BUSY); end
    @(negedge CK49);
    RESET_N = 1'b1;
    model_reset();
    // Flush power-up RAM contents by reading every address of both banks.
    VBANK = 1'b0;
    for (int a = 0; a < 256; a++) begin HCNT = 8'(a); tick(); end
    VBANK = 1'b1;
    for (int a = 0; a < 256; a++) begin HCNT = 8'(a); tick(); end
    for (int b = 0; b < 2; b++) for (int a = 0; a < 256; a++) m_mem[b][a] = 0;
    HCNT = 8'h00;
    tick();
    n_cmp++;
    if (PIX_OUT !== 4'(exp_pix)) begin n_fail++; $display("FAIL cleared_pix got=%0h want=%0h", PIX_OUT, exp_pix); end
    n_cmp++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%0b want=0", BUSY); end
  endtask

  task automatic test_basic();
    HCNT = 8'h00;
    set_bank(1'b0);
    col(8'h40);
    dat(32'h12345678, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (BUSY !== exp_busy) begin n_fail++; $display("FAIL basic_busy step=%0d got=%0b want=%0b", i, BUSY, exp_busy); end
      tick();
    end
    set_bank(1'b1);
    for (int i = 0; i < 8; i++) begin
      HCNT = 8'(8'h40 + i);
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'(exp_pix) || PIX_OUT !== 4'(i + 1)) begin
        n_fail++; $display("FAIL basic_rd addr=%02h got=%0h want=%0h", HCNT, PIX_OUT, i + 1);
      end
    end
  endtask

  task automatic test_flip();
    int want[8];
    want = '{9, 12, 0, 11, 0, 10, 0, 0};
    col(8'h10);
    dat(32'h90000000, 1'b0, 1'b0);
    idle(8);
    dat(32'h00A0B0C0, 1'b1, 1'b0);
    idle(8);
    set_bank(1'b0);
    for (int i = 0; i < 8; i++) begin
      HCNT = 8'(8'h10 + i);
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'(exp_pix) || PIX_OUT !== 4'(want[i])) begin
        n_fail++; $display("FAIL flip_rd addr=%02h got=%0h want=%0h", HCNT, PIX_OUT, want[i]);
      end
    end
  endtask

  task automatic test_wrap();
    col(8'hFD);
    dat(32'h11111111, 1'b0, 1'b0);
    idle(8);
    set_bank(1'b1);
    for (int i = 0; i < 9; i++) begin
      HCNT = 8'((8'hFC + i) % 256);
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'(exp_pix) || PIX_OUT !== ((i == 0) ? 4'h0 : 4'h1)) begin
        n_fail++; $display("FAIL wrap_rd addr=%02h got=%0h want=%0h", HCNT, PIX_OUT, (i == 0) ? 0 : 1);
      end
    end
  endtask

  task automatic test_ocs_abort();
    int want80[8];
    want80 = '{9, 10, 11, 12, 13, 14, 15, 1};
    col(8'h30);
    dat(32'hFFFFFFFF, 1'b0, 1'b1);
    n_cmp++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL ocs_busy got=%0b want=0", BUSY); end
    idle(2);
    col(8'h20);
    dat(32'h12345678, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (BUSY !== 1'b1) begin n_fail++; $display("FAIL abort_busy1 step=%0d got=%0b want=1", i, BUSY); end
    end
    // Second load with OCOL falling on the same edge: the address bypasses the latch.
    OCOL = 1'b0; ODAT = 1'b0; OCS = 1'b0; XPOS = 8'h80; GFX = 32'h9ABCDEF1; OFLP = 1'b0;
    tick();
    OCOL = 1'b1; ODAT = 1'b1; OCS = 1'b1;
    n_cmp++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL abort_busy2 got=%0b want=1", BUSY); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (BUSY !== exp_busy) begin n_fail++; $display("FAIL abort_busy3 step=%0d got=%0b want=%0b", i, BUSY, exp_busy); end
    end
    set_bank(1'b0);
    for (int i = 0; i < 8; i++) begin
      HCNT = 8'(8'h1E + i);
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'(exp_pix)) begin n_fail++; $display("FAIL abort_rd1 addr=%02h got=%0h want=%0h", HCNT, PIX_OUT, exp_pix); end
    end
    for (int i = 0; i < 8; i++) begin
      HCNT = 8'(8'h30 + i);
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'h0) begin n_fail++; $display("FAIL ocs_rd addr=%02h got=%0h want=0", HCNT, PIX_OUT); end
    end
    for (int i = 0; i < 8; i++) begin
      HCNT = 8'(8'h80 + i);
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'(exp_pix) || PIX_OUT !== 4'(want80[i])) begin
        n_fail++; $display("FAIL abort_rd2 addr=%02h got=%0h want=%0h", HCNT, PIX_OUT, want80[i]);
      end
    end
  endtask

  task automatic test_clear_toggle();
    col(8'h60);
    dat(32'h50000000, 1'b0, 1'b0);
    idle(8);
    HCNT = 8'h00;
    set_bank(1'b1);
    HCNT = 8'h60;
    tick();
    n_cmp++;
    if (PIX_OUT !== 4'h5) begin n_fail++; $display("FAIL clear_rd1 got=%0h want=5", PIX_OUT); end
    tick();
    n_cmp++;
    if (PIX_OUT !== 4'h0) begin n_fail++; $display("FAIL clear_rd2 got=%0h want=0", PIX_OUT); end
    col(8'h70);
    dat(32'h77777777, 1'b0, 1'b0);
    idle(3);
    set_bank(1'b0);
    n_cmp++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL toggle_busy got=%0b want=0", BUSY); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (BUSY !== exp_busy) begin n_fail++; $display("FAIL toggle_idle step=%0d got=%0b want=%0b", i, BUSY, exp_busy); end
    end
    for (int i = 0; i < 8; i++) begin
      HCNT = 8'(8'h70 + i);
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'(exp_pix) || PIX_OUT !== ((i < 3) ? 4'h7 : 4'h0)) begin
        n_fail++; $display("FAIL toggle_rd1 addr=%02h got=%0h want=%0h", HCNT, PIX_OUT, (i < 3) ? 7 : 0);
      end
    end
    set_bank(1'b1);
    for (int i = 0; i < 8; i++) begin
      HCNT = 8'(8'h70 + i);
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'h0) begin n_fail++; $display("FAIL toggle_rd0 addr=%02h got=%0h want=0", HCNT, PIX_OUT); end
    end
  endtask

  task automatic test_reset_mid();
    set_bank(1'b0);
    col(8'h50);
    dat(32'h33333333, 1'b0, 1'b0);
    idle(8);
    set_bank(1'b1);
    col(8'h90);
    dat(32'h12345678, 1'b0, 1'b0);
    HCNT = 8'h50;
    tick();
    n_cmp++;
    if (PIX_OUT !== 4'h3) begin n_fail++; $display("FAIL pre_reset_pix got=%0h want=3", PIX_OUT); end
    n_cmp++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy got=%0b want=1", BUSY); end
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (PIX_OUT !== 4'h0) begin n_fail++; $display("FAIL async_reset_pix got=%0h want=0", PIX_OUT); end
    n_cmp++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got=%0b want=0", BUSY); end
    @(negedge CK49);
    RESET_N = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (BUSY !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy step=%0d got=%0b want=0", i, BUSY); end
    end
    set_bank(1'b0);
    for (int i = 0; i < 8; i++) begin
      HCNT = 8'(8'h90 + i);
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'(exp_pix) || PIX_OUT !== ((i == 0) ? 4'h1 : 4'h0)) begin
        n_fail++; $display("FAIL post_reset_rd addr=%02h got=%0h want=%0h", HCNT, PIX_OUT, (i == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] g;
    for (int t = 0; t < 600; t++) begin
      CEN   = ($urandom_range(7) != 0);
      OCOL  = ($urandom_range(5) != 0);
      ODAT  = ($urandom_range(9) != 0);
      OCS   = ($urandom_range(3) == 0);
      OFLP  = 1'($urandom_range(1));
      XPOS  = 8'($urandom);
      HCNT  = 8'($urandom);
      if ($urandom_range(39) == 0) VBANK = ~VBANK;
      g = $urandom;
      for (int n = 0; n < NPIX; n++) if ($urandom_range(2) == 0) g[n*4 +: 4] = 4'h0;
      GFX = g;
      tick();
      n_cmp++;
      if (PIX_OUT !== 4'(exp_pix)) begin n_fail++; $display("FAIL rand_pix t=%0d got=%0h want=%0h", t, PIX_OUT, exp_pix); end
      n_cmp++;
      if (BUSY !== exp_busy) begin n_fail++; $display("FAIL rand_busy t=%0d got=%0b want=%0b", t, BUSY, exp_busy); end
    end
    CEN = 1'b1; OCOL = 1'b1; ODAT = 1'b1; OCS = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_wrap();
    test_ocs_abort();
    test_clear_toggle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_linebuf_writer.md
Name: sprite_linebuf_writer

Overview:
- Consumer end of the k503 sprite interface.
- Takes the OCS/OFLP/ODAT/OCOL strobes plus the fetched sprite graphics word and sprite X position, and serialises 4bpp pixels into a ping-pong sprite line buffer.
- While one bank is written, the other bank is read out at pixel rate and cleared behind the read.
- Sits between the k503 and sprite graphics ROMs on one side and the sprite colour lookup on the other.

Parameters:
- PIX_W, 4, bits per sprite pixel (colour code); 0 is transparent.
- X_W, 8, line buffer address width; buffer depth is 2**X_W per bank.
- NPIX, 8, pixels per graphics word; GFX width is NPIX*PIX_W.

Ports:
- CK49  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- CEN  in  1  pixel clock enable; all state advances only on CK49 edges with CEN=1.
- OCS  in  1  sprite-on-line select from k503, active low.
- OFLP  in  1  sprite horizontal flip from k503.
- OCOL  in  1  active-low strobe: latch XPOS.
- ODAT  in  1  active-low strobe: load graphics word and start writing.
- XPOS  in  X_W  sprite X start position.
- GFX  in  NPIX*PIX_W  graphics word; nibble i = GFX[i*PIX_W +: PIX_W].
- VBANK  in  1  write-bank select (VCNT[0]); the read bank is ~VBANK.
- HCNT  in  X_W  read address for pixel output.
- PIX_OUT  out  PIX_W  registered sprite pixel for the current read position.
- BUSY  out  1  high while the shifter holds unwritten pixels.

Behaviour:
- Reset: PIX_OUT=0, BUSY=0, shifter count=0, x_latch=0, previous-strobe registers=1, previous VBANK captured as 0. RAM contents are not reset; the first full read pass of each bank clears it.
- Strobe detection: a strobe acts on a CEN edge where it is 0 and its registered previous value (sampled at the last CEN) is 1. A held-low strobe acts once only.
- OCOL fall: x_latch <= XPOS.
- ODAT fall with OCS=0: load shifter <= GFX, flip <= OFLP, count <= NPIX, waddr <= x_latch. If OCOL falls on the same edge, waddr <= XPOS (bypass).
- ODAT fall with OCS=1: ignored; shifter state unchanged.
- ODAT fall while count>0: the new load replaces the old one; remaining old pixels are dropped.
- Write cycle: on each CEN edge with count>0 that is not a load edge:
  - Emit one pixel: flip=0 takes nibble NPIX-1-k, flip=1 takes nibble k, where k = NPIX-count.
  - If the pixel is nonzero, write bank[VBANK][waddr] <= pixel; last writer wins.
  - waddr <= waddr+1, wrapping modulo 2**X_W (255 -> 0).
  - count <= count-1.
- The first pixel is written on the CEN edge after the load edge. A full word takes NPIX CEN edges.
- BUSY = (count != 0), registered.
- Bank toggle: on a CEN edge where VBANK differs from its previous sample, count <= 0 and any pending pixels are discarded. A load on the same edge is honoured and targets the new write bank.
- Read/clear: on every CEN edge, PIX_OUT <= bank[~VBANK][HCNT], then bank[~VBANK][HCNT] <= 0 (read-before-write). Latency is 1 CEN edge from HCNT to PIX_OUT.
- Port separation: the write bank takes only sprite writes and the read bank takes only clears, so each bank needs one write port per cycle.
- CEN=0: no state changes; PIX_OUT holds.

Decomposition:
- Shared package sprite_pkg holds PIX_W and X_W defaults, typedef pix_t (logic [PIX_W-1:0]) and xaddr_t, and a function nibble_sel(word, idx, flip).
- One natural sub-module, linebuf_bank: a 2**X_W x PIX_W RAM with one synchronous write port and one synchronous read port with read-first semantics. It is instantiated twice.
- Bank steering, strobe edge detection and the shifter stay in the top module.

Test Plan:
- Basic write/readback:
  - Stimulus: VBANK=0, OCOL fall with XPOS=0x40; ODAT fall with OCS=0, OFLP=0, GFX=0x12345678. Toggle VBANK to 1 and sweep HCNT 0x40..0x47.
  - Required: PIX_OUT = 1,2,3,4,5,6,7,8, one CEN after each address.
- Flip and transparency:
  - Stimulus: OFLP=1, GFX=0x00A0B0C0, XPOS=0x10.
  - Required: addresses 0x10..0x17 read 0,C,0,B,0,A,0,0. A prior non-zero value at 0x10 remains (zero pixels do not overwrite).
- Wrap-around:
  - Stimulus: XPOS=0xFD, GFX=0x11111111.
  - Required: addresses FD, FE, FF, 00..04 read 1. Address FC reads 0.
- OCS reject and re-load abort:
  - Stimulus: ODAT fall with OCS=1. Then ODAT fall at XPOS=0x20, with a second ODAT fall at XPOS=0x80 three CENs later.
  - Required: the OCS=1 load writes nothing. Only 0x20..0x22 from word 1 are written; word 2 fully fills 0x80..0x87. BUSY stays 1 through the switch.
- Clear-on-read and bank toggle:
  - Stimulus: read the bank twice at the same HCNT.
  - Required: first read returns data, second returns 0.
  - Stimulus: toggle VBANK mid-word (count=5).
  - Required: BUSY drops next CEN and no further writes occur in either bank.
- Reset mid-operation:
  - Stimulus: assert RESET_N=0 asynchronously with BUSY=1.
  - Required: PIX_OUT=0 and BUSY=0 immediately; no write occurs after release until a new ODAT fall.
